tmr_timestamp_fifo: RTL and testbench

//   Downstream consumer of the TMR-voted free-running counter (q_out of the TMR counter top).

---
 rtl/tmr_timestamp_fifo.sv | 137 +++++++++++++
 tb/tb_tmr_timestamp_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_timestamp_fifo.sv
// tmr_timestamp_fifo: captures the voted counter value on each event strobe into a
// small FIFO and presents the queued timestamps on a valid/ready stream. Events that
// arrive while the FIFO is full (with no pop on the same edge) are dropped. A dropped
// event sets a sticky overflow flag and increments a saturating drop counter.
// Optional build macro TS_TMR_PTR_EN: the write and read pointers are triplicated and
// majority voted. A pointer copy that disagrees with the vote raises ptr_fault for one
// cycle. Without the macro, single pointers are used and ptr_fault is tied to 0.
module tmr_timestamp_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     event_in,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [WIDTH-1:0]         ts_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     ptr_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PW-1:0]     w_wr_ptr;
    logic [PW-1:0]     w_rd_ptr;
    logic [PW-1:0]     w_wr_nxt;
    logic [PW-1:0]     w_rd_nxt;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    // The extra wrap bit tells a full FIFO apart from an empty one.
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) && (w_wr_ptr[AW] != w_rd_ptr[AW]);
    assign w_pop   = !w_empty && ts_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign w_push  = event_in && (!w_full || w_pop);
    assign w_drop  = event_in && w_full && !w_pop;

    assign w_wr_nxt = w_wr_ptr + PW'(w_push);
    assign w_rd_nxt = w_rd_ptr + PW'(w_pop);

`ifdef TS_TMR_PTR_EN
    logic [PW-1:0] r_wr_ptr_a, r_wr_ptr_b, r_wr_ptr_c;
    logic [PW-1:0] r_rd_ptr_a, r_rd_ptr_b, r_rd_ptr_c;
    logic          r_ptr_fault;
    logic          w_mis;

    assign w_wr_ptr = (r_wr_ptr_a & r_wr_ptr_b) | (r_wr_ptr_a & r_wr_ptr_c) | (r_wr_ptr_b & r_wr_ptr_c);
    assign w_rd_ptr = (r_rd_ptr_a & r_rd_ptr_b) | (r_rd_ptr_a & r_rd_ptr_c) | (r_rd_ptr_b & r_rd_ptr_c);
    assign w_mis    = (r_wr_ptr_a != w_wr_ptr) || (r_wr_ptr_b != w_wr_ptr) || (r_wr_ptr_c != w_wr_ptr) ||
                      (r_rd_ptr_a != w_rd_ptr) || (r_rd_ptr_b != w_rd_ptr) || (r_rd_ptr_c != w_rd_ptr);

    // Every copy reloads from the voted next value, so a single upset heals within one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_a  <= '0;
            r_wr_ptr_b  <= '0;
            r_wr_ptr_c  <= '0;
            r_rd_ptr_a  <= '0;
            r_rd_ptr_b  <= '0;
            r_rd_ptr_c  <= '0;
            r_ptr_fault <= 1'b0;
        end else begin
            r_wr_ptr_a  <= w_wr_nxt;
            r_wr_ptr_b  <= w_wr_nxt;
            r_wr_ptr_c  <= w_wr_nxt;
            r_rd_ptr_a  <= w_rd_nxt;
            r_rd_ptr_b  <= w_rd_nxt;
            r_rd_ptr_c  <= w_rd_nxt;
            r_ptr_fault <= w_mis;
        end
    end

    assign ptr_fault = r_ptr_fault;
`else
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    assign w_wr_ptr = r_wr_ptr;
    assign w_rd_ptr = r_rd_ptr;

    // Single-copy pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

    assign ptr_fault = 1'b0;
`endif

    // Timestamp storage. Reset clears it so no stale data survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[w_wr_ptr[AW-1:0]] <= count_in;
        end
    end

    // Overflow tracking. On the same edge, a drop takes priority over the clear,
    // so a simultaneous drop and clear leaves a count of exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (overflow_clr)    r_drop_cnt <= DROP_W'(1);
            else if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign ts_valid = !w_empty;
    assign ts_data  = w_empty ? '0 : r_mem[w_rd_ptr[AW-1:0]];
    assign level    = w_wr_ptr - w_rd_ptr;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_tmr_timestamp_fifo.sv
// Bench for tmr_timestamp_fifo: a queue-based model is checked on every cycle,
// plus literal expectations for the directed scenarios.
module tb_tmr_timestamp_fifo;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  count_in = '0;
    logic              event_in = 1'b0;
    logic              ts_valid;
    logic              ts_ready = 1'b0;
    logic [WIDTH-1:0]  ts_data;
    logic [2:0]        level;
    logic              overflow;
    logic              overflow_clr = 1'b0;
    logic [DROP_W-1:0] drop_cnt;
    logic              ptr_fault;

    tmr_timestamp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .event_in(event_in),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .level(level),
        .overflow(overflow), .overflow_clr(overflow_clr), .drop_cnt(drop_cnt),
        .ptr_fault(ptr_fault)
    );

    always #5 clk = ~clk;

    // Model state
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    int               m_dcnt = 0;
    logic             m_pf = 1'b0;
    logic             pf_pending = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_dcnt = 0;
        m_pf   = 1'b0;
        pf_pending = 1'b0;
    endtask

    // Apply one edge of the FIFO rules to the model.
    task automatic model_edge(input logic ev, input logic [WIDTH-1:0] cnt, input logic rdy, input logic clr);
        logic pop, full;
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_pf = pf_pending;
        pf_pending = 1'b0;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (ev && full && !pop) begin
            m_ovf  = 1'b1;
            m_dcnt = clr ? 1 : ((m_dcnt == 255) ? 255 : m_dcnt + 1);
        end else begin
            if (ev) mq.push_back(cnt);
            if (clr) begin
                m_ovf  = 1'b0;
                m_dcnt = 0;
            end
        end
    endtask

    task automatic compare();
        chk("ts_valid",  WIDTH'(ts_valid),  WIDTH'(mq.size() > 0));
        chk("ts_data",   ts_data,           (mq.size() > 0) ? mq[0] : '0);
        chk("level",     WIDTH'(level),     WIDTH'(mq.size()));
        chk("overflow",  WIDTH'(overflow),  WIDTH'(m_ovf));
        chk("drop_cnt",  WIDTH'(drop_cnt),  WIDTH'(m_dcnt));
        chk("ptr_fault", WIDTH'(ptr_fault), WIDTH'(m_pf));
    endtask

    // Drive one cycle of inputs, step the model at the edge, and compare at the falling edge.
    task automatic cyc(input logic ev, input logic [WIDTH-1:0] cnt, input logic rdy, input logic clr);
        event_in = ev; count_in = cnt; ts_ready = rdy; overflow_clr = clr;
        @(posedge clk);
        model_edge(ev, cnt, rdy, clr);
        @(negedge clk);
        compare();
    endtask

    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] ones;

    initial begin
        ones = '1;
        // 1. Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc(1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        chk("rst_level_lit", WIDTH'(level), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, {$urandom, $urandom}, 1'($urandom), 1'b0);
        chk("idle_valid_lit", WIDTH'(ts_valid), 0);

        // 2. Four captures, then drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 100 + i, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        chk("fill_level_lit", WIDTH'(level), 4);
        chk("fill_valid_lit", WIDTH'(ts_valid), 1);
        chk("fill_head_lit",  ts_data, 100);
        for (int i = 0; i < 4; i++) begin
            chk("drain_seq_lit", ts_data, 100 + i);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drained_valid_lit", WIDTH'(ts_valid), 0);
        chk("drained_data_lit",  ts_data, 0);

        // 3. Drops while full, then clear with a simultaneous drop
        for (int i = 0; i < 4; i++) cyc(1'b1, 200 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 300 + i, 1'b0, 1'b0);
        chk("drop3_ovf_lit",   WIDTH'(overflow), 1);
        chk("drop3_cnt_lit",   WIDTH'(drop_cnt), 3);
        chk("drop3_level_lit", WIDTH'(level), 4);
        cyc(1'b1, 400, 1'b0, 1'b1);
        chk("clrdrop_ovf_lit", WIDTH'(overflow), 1);
        chk("clrdrop_cnt_lit", WIDTH'(drop_cnt), 1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("clr_ovf_lit", WIDTH'(overflow), 0);

        // 4. Full: push and pop on the same edge
        cyc(1'b1, 500, 1'b1, 1'b0);
        chk("pp_level_lit", WIDTH'(level), 4);
        chk("pp_ovf_lit",   WIDTH'(overflow), 0);
        chk("pp_head_lit",  ts_data, 201);
        for (int i = 0; i < 4; i++) begin
            last = ts_data;
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        chk("pp_tail_lit", last, 500);

        // 5. Saturating drop counter, then continuous streaming across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 600 + i, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 700 + i, 1'b0, 1'b0);
        chk("sat_cnt_lit", WIDTH'(drop_cnt), 255);
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, (i == 3) ? ones : ((i == 4) ? '0 : WIDTH'(1000 + i)), 1'b1, 1'b0);
        chk("stream_level_lit", WIDTH'(level), 1);
        chk("stream_head_lit",  ts_data, 1019);
        cyc(1'b0, 0, 1'b1, 1'b0);

        // Mid-operation reset discards queued entries at once
        for (int i = 0; i < 3; i++) cyc(1'b1, 2000 + i, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("async_rst_valid_lit", WIDTH'(ts_valid), 0);
        chk("async_rst_level_lit", WIDTH'(level), 0);
        cyc(1'b1, 2100, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 2200, 1'b0, 1'b0);
        chk("post_rst_head_lit", ts_data, 2200);
        cyc(1'b0, 0, 1'b1, 1'b0);

        // 6. Pointer-copy upset
`ifdef TS_TMR_PTR_EN
        for (int i = 0; i < 2; i++) cyc(1'b1, 3000 + i, 1'b0, 1'b0);
        dut.r_wr_ptr_a = ~dut.r_wr_ptr_a;
        pf_pending = 1'b1;
        cyc(1'b1, 3002, 1'b0, 1'b0);
        chk("pf_set_lit", WIDTH'(ptr_fault), 1);
        cyc(1'b0, 0, 1'b0, 1'b0);
        chk("pf_clear_lit", WIDTH'(ptr_fault), 0);
        for (int i = 0; i < 3; i++) begin
            chk("pf_data_lit", ts_data, 3000 + i);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
`else
        for (int i = 0; i < 4; i++) cyc(1'b1, 3000 + i, 1'b1, 1'b0);
        chk("pf_tied_lit", WIDTH'(ptr_fault), 0);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
